// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access unit.
// Holds the FSM state encoding, the byte-lane count and the RAM index-width helper.
// Optional feature macro used by the importing top: DMEM_RANGE_CHECK_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LANES = 4;

  // Number of index bits needed to address a power-of-two RAM; never below 1.
  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Data RAM: DEPTH x DATA_BITS array with per-byte write enables and a registered read port.
// Ports: clk/rst_n; i_wr_en/i_wr_sel/i_wdata write side; i_rd_en/i_rd_clr read side; i_idx shared word index;
//        o_rdata holds the last read word (reset to 0, forced to 0 when i_rd_clr). Array contents are not reset.
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int DATA_BITS = 32,
  parameter int IDX_W     = idx_bits(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_en,
  input  logic [LANES-1:0]     i_wr_sel,
  input  logic                 i_rd_en,
  input  logic                 i_rd_clr,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic [DATA_BITS-1:0] i_wdata,
  output logic [DATA_BITS-1:0] o_rdata
);

  localparam int LANE_W = DATA_BITS / LANES;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [DATA_BITS-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (i_wr_en && i_wr_sel[l]) begin
        r_mem[i_idx][l*LANE_W +: LANE_W] <= i_wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  // Read register keeps its value until the next read commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_rd_en) begin
      r_rdata <= i_rd_clr ? '0 : r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory stage: runs each load/store as an IDLE->BUSY(WAIT_STATES+1 cycles)->RESP transaction, stalling the pipeline.
// Ports: req_valid/req_we/addr/mem_in/mem_sel request (latched on accept); stall combinational hold;
//        done/rd_valid/addr_err one-cycle pulses in RESP; rd_data registered load word. Macro: DMEM_RANGE_CHECK_EN.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BITS   = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] mem_in,
  input  logic [LANES-1:0]     mem_sel,
  output logic                 stall,
  output logic                 done,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 addr_err
);

  localparam int IDX_W = idx_bits(DEPTH);
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  // Upper address bits are ignored; addresses alias modulo DEPTH.
  localparam bit RANGE_EN = 1'b0;
`endif

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_we;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_oor;
  logic [DATA_BITS-1:0] r_wdata;
  logic [LANES-1:0]     r_sel;
  logic                 r_done;
  logic                 r_rd_valid;
  logic                 r_addr_err;

  logic                 w_addr_oor;
  logic                 w_commit;

  // Out-of-range is decided on the address seen at accept and carried with the request.
  assign w_addr_oor = RANGE_EN & (|addr[ADDR_BITS-1:IDX_W]);
  assign w_commit   = (r_state == BUSY) && (r_cnt == '0);

  dmem_byte_ram #(
    .DEPTH    (DEPTH),
    .DATA_BITS(DATA_BITS),
    .IDX_W    (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr_en (w_commit & r_we & ~r_oor),
    .i_wr_sel(r_sel),
    .i_rd_en (w_commit & ~r_we),
    .i_rd_clr(r_oor),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_oor      <= 1'b0;
      r_wdata    <= '0;
      r_sel      <= '0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_addr_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_idx   <= addr[IDX_W-1:0];
            r_oor   <= w_addr_oor;
            r_wdata <= mem_in;
            r_sel   <= mem_sel;
            r_cnt   <= CNT_W'(WAIT_STATES);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // RAM commits on this same edge; response flags line up with RESP.
            r_state    <= RESP;
            r_done     <= 1'b1;
            r_rd_valid <= ~r_we;
            r_addr_err <= r_oor;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Dropping stall in RESP lets the pipeline advance on the edge that ends the transaction.
  assign stall    = req_valid & (r_state != RESP);
  assign done     = r_done;
  assign rd_valid = r_rd_valid;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [31:0] addr   [2];
  logic [31:0] mem_in [2];
  logic [3:0]  mem_sel[2];
  logic [1:0]  stall;
  logic [1:0]  done;
  logic [1:0]  rd_valid;
  logic [1:0]  addr_err;
  logic [31:0] rd_data[2];

  int errors = 0;
  int checks = 0;

  // Reference model: word array per instance plus the last load result.
  logic [31:0] mem_m  [2][DEPTH];
  bit          known  [2][DEPTH];
  logic [31:0] last_rd[2];

  // Instance 0: WAIT_STATES=1, instance 1: WAIT_STATES=0.
  dmem_access_unit #(.ADDR_BITS(32), .DATA_BITS(32), .DEPTH(DEPTH), .WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_we(req_we[0]), .addr(addr[0]),
    .mem_in(mem_in[0]), .mem_sel(mem_sel[0]), .stall(stall[0]), .done(done[0]),
    .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .addr_err(addr_err[0]));

  dmem_access_unit #(.ADDR_BITS(32), .DATA_BITS(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_we(req_we[1]), .addr(addr[1]),
    .mem_in(mem_in[1]), .mem_sel(mem_sel[1]), .stall(stall[1]), .done(done[1]),
    .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .addr_err(addr_err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int u, input logic [31:0] exp_rd);
    check({tag, "_stall"}, 32'(stall[u]), 32'd0);
    check({tag, "_done"}, 32'(done[u]), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid[u]), 32'd0);
    check({tag, "_addr_err"}, 32'(addr_err[u]), 32'd0);
    check({tag, "_rd_data"}, rd_data[u], exp_rd);
  endtask

  // Runs one transaction on instance u. Entry and exit are #1 after a rising edge.
  task automatic txn(input int u, input bit we, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit scramble);
    int ws;
    int idx;
    int stalls;
    bit oor;
    bit got;
    logic [31:0] exp_rd;
    ws     = (u == 0) ? 1 : 0;
    idx    = int'(a % DEPTH);
    oor    = RC && (a >= DEPTH);
    exp_rd = we ? last_rd[u] : (oor ? 32'd0 : mem_m[u][idx]);
    if (we && !oor) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) mem_m[u][idx][8*i +: 8] = d[8*i +: 8];
      known[u][idx] = 1'b1;
    end
    if (!we) last_rd[u] = exp_rd;

    req_valid[u] = 1'b1; req_we[u] = we; addr[u] = a; mem_in[u] = d; mem_sel[u] = s;
    got = 1'b0; stalls = 0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (done[u]) begin
        got = 1'b1;
        check($sformatf("u%0d_done_cycle", u), 32'(n), 32'(ws + 3));
        check($sformatf("u%0d_stall_cycles", u), 32'(stalls), 32'(ws + 2));
        check($sformatf("u%0d_stall_in_resp", u), 32'(stall[u]), 32'd0);
        check($sformatf("u%0d_rd_valid", u), 32'(rd_valid[u]), 32'(!we));
        check($sformatf("u%0d_addr_err", u), 32'(addr_err[u]), 32'(oor));
        check($sformatf("u%0d_rd_data", u), rd_data[u], exp_rd);
      end else begin
        if (stall[u]) stalls++;
        @(posedge clk); #1;
        if (scramble) begin
          req_we[u] = 1'($urandom); addr[u] = $urandom; mem_in[u] = $urandom; mem_sel[u] = 4'($urandom);
        end
      end
    end
    if (!got) check($sformatf("u%0d_timeout", u), 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
  endtask

  logic [31:0] ra, rd;
  bit          rw;
  int          ru;

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_we = '0;
    for (int u = 0; u < 2; u++) begin
      addr[u] = '0; mem_in[u] = '0; mem_sel[u] = '0; last_rd[u] = '0;
      for (int i = 0; i < DEPTH; i++) known[u][i] = 1'b0;
    end

    // Reset state, then idle with no requests.
    #12;
    check_idle_outputs("rst_u0", 0, 32'd0);
    check_idle_outputs("rst_u1", 1, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    check_idle_outputs("idle_u0", 0, 32'd0);
    check_idle_outputs("idle_u1", 1, 32'd0);

    // Full-word store/load, WAIT_STATES=1.
    txn(0, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    txn(0, 1'b0, 32'd5, 32'h0, 4'h0, 1'b0);
    check("full_word", rd_data[0], 32'hDEADBEEF);

    // Byte-lane merge.
    txn(0, 1'b1, 32'd7, 32'h11223344, 4'hF, 1'b0);
    txn(0, 1'b1, 32'd7, 32'h00AA0000, 4'b0100, 1'b0);
    txn(0, 1'b0, 32'd7, 32'h0, 4'hF, 1'b0);
    check("lane_merge", rd_data[0], 32'h11AA3344);

    // Empty byte select still handshakes and leaves RAM alone.
    txn(0, 1'b1, 32'd7, 32'hFFFFFFFF, 4'b0000, 1'b0);
    txn(0, 1'b0, 32'd7, 32'h0, 4'h0, 1'b0);

    // Zero-wait back-to-back stores, then one with inputs scrambled during BUSY.
    txn(1, 1'b1, 32'd2, 32'hCAFEF00D, 4'hF, 1'b0);
    txn(1, 1'b1, 32'd3, 32'h0BADC0DE, 4'hF, 1'b0);
    txn(1, 1'b1, 32'd4, 32'h55667788, 4'b1010, 1'b1);
    txn(1, 1'b0, 32'd2, 32'h0, 4'h0, 1'b1);
    txn(1, 1'b0, 32'd3, 32'h0, 4'h0, 1'b0);
    txn(0, 1'b1, 32'd9, 32'h99999999, 4'hF, 1'b1);
    txn(0, 1'b0, 32'd9, 32'h0, 4'h0, 1'b0);

    // Reset in the middle of a store: it must not commit.
    txn(0, 1'b1, 32'd3, 32'h33333333, 4'hF, 1'b0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; addr[0] = 32'd3; mem_in[0] = 32'hBAADBAAD; mem_sel[0] = 4'hF;
    @(posedge clk); #1;   // accepted, now BUSY with cnt=1
    rst_n = 1'b0; req_valid[0] = 1'b0;
    #1;
    check_idle_outputs("midrst_u0", 0, 32'd0);
    last_rd[0] = '0; last_rd[1] = '0;
    @(posedge clk); #1; rst_n = 1'b1;
    txn(0, 1'b0, 32'd3, 32'h0, 4'h0, 1'b0);
    check("midrst_old_value", rd_data[0], 32'h33333333);

    // Range: addr DEPTH+9 against word 9.
    txn(0, 1'b1, 32'd9, 32'h09090909, 4'hF, 1'b0);
    txn(0, 1'b1, 32'(DEPTH + 9), 32'hA5A5A5A5, 4'hF, 1'b0);
    txn(0, 1'b0, 32'(DEPTH + 9), 32'h0, 4'h0, 1'b0);
    txn(0, 1'b0, 32'd9, 32'h0, 4'h0, 1'b0);
    check("range_word9", rd_data[0], RC ? 32'h09090909 : 32'hA5A5A5A5);

    // Randomized traffic on both instances.
    for (int k = 0; k < 60; k++) begin
      ru = int'($urandom_range(0, 1));
      rw = 1'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? 32'(DEPTH + $urandom_range(0, 15)) : 32'($urandom_range(0, 15));
      rd = $urandom;
      if (!rw && !(RC && ra >= DEPTH) && !known[ru][ra % DEPTH]) rw = 1'b1;
      txn(ru, rw, ra, rd, 4'($urandom), 1'($urandom));
    end

    @(negedge clk);
    check_idle_outputs("final_u0", 0, last_rd[0]);
    check_idle_outputs("final_u1", 1, last_rd[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
